spi_txn_arbiter: RTL

Sequences full-duplex word transfers through the SPI byte/word engine and shares that engine between two requesters: the CPU coprocessor path (requester 0) and a secondary master such as a boot loader or DMA (requester 1). It sits between the requesters and the `spi` engine: it grants the engine round-robin, drives per-requester chip selects, issues each MOSI word with a one-cycle valid pulse, collects the matching MISO word, and signals completion or timeout.

---
 rtl/spi_txn_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/spi_txn_arbiter.sv
// Two-requester round-robin arbiter that sequences full-duplex word bursts
// through a shared SPI engine, with per-requester chip selects and an RX timeout.
module spi_txn_arbiter #(
  parameter int W_DATA  = 32,
  parameter int W_LEN   = 4,
  parameter int CS_GAP  = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  input  logic [2*W_LEN-1:0]    req_len,
  input  logic [2*W_DATA-1:0]   req_wdata,
  output logic [1:0]            req_wready,
  output logic [W_DATA-1:0]     rsp_data,
  output logic [1:0]            rsp_valid,
  output logic [1:0]            done,
  output logic [1:0]            err,
  input  logic                  spi_tx_ready,
  output logic [W_DATA-1:0]     spi_tx_data,
  output logic                  spi_tx_valid,
  input  logic [W_DATA-1:0]     spi_rx_data,
  input  logic                  spi_rx_valid,
  output logic [1:0]            spi_cs_n,
  output logic                  busy,
  output logic                  owner
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int GW = $clog2(CS_GAP + 1);
  localparam logic [TW-1:0]  T_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0]  G_LAST  = GW'(CS_GAP - 1);
  localparam logic [W_LEN:0] REM_ONE = (W_LEN + 1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    LOAD,
    WAIT_RX,
    NEXT,
    GAP
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                owner_q;
  logic                grant_sel;
  logic                do_grant;
  logic                tx_fire;
  logic                rx_hit;
  logic                timeout_hit;
  logic                last_word;
  logic [W_LEN:0]      remaining_q;
  logic [TW-1:0]       tcnt_q;
  logic [GW-1:0]       gcnt_q;
  logic [1:0]          cs_n_q;
  logic [W_DATA-1:0]   rsp_data_q;
  logic [1:0]          rsp_valid_q;
  logic [1:0]          done_q;
  logic [1:0]          owner_oh;
  logic [W_LEN-1:0]    len_sel;
  logic [W_DATA-1:0]   wdata_sel;

  assign owner_oh  = owner_q ? 2'b10 : 2'b01;
  assign len_sel   = grant_sel ? req_len[2*W_LEN-1 -: W_LEN] : req_len[W_LEN-1:0];
  assign wdata_sel = owner_q ? req_wdata[2*W_DATA-1 -: W_DATA] : req_wdata[W_DATA-1:0];

  always_comb begin
    state_d     = state_q;
    grant_sel   = owner_q;
    do_grant    = 1'b0;
    tx_fire     = 1'b0;
    rx_hit      = 1'b0;
    timeout_hit = 1'b0;
    last_word   = 1'b0;
    case (state_q)
      IDLE: begin
        // On a collision the requester that did not hold the last grant wins.
        case (req_valid)
          2'b01: begin
            grant_sel = 1'b0;
            do_grant  = 1'b1;
          end
          2'b10: begin
            grant_sel = 1'b1;
            do_grant  = 1'b1;
          end
          2'b11: begin
            grant_sel = ~owner_q;
            do_grant  = 1'b1;
          end
          default: do_grant = 1'b0;
        endcase
        if (do_grant) state_d = GRANT;
      end
      GRANT: state_d = LOAD;
      LOAD: begin
        if (spi_tx_ready) begin
          tx_fire = 1'b1;
          state_d = WAIT_RX;
        end
      end
      WAIT_RX: begin
        if (spi_rx_valid) begin
          rx_hit  = 1'b1;
          state_d = NEXT;
        end else if (tcnt_q == T_LAST) begin
          timeout_hit = 1'b1;
          state_d     = GAP;
        end
      end
      NEXT: begin
        if (remaining_q <= REM_ONE) begin
          last_word = 1'b1;
          state_d   = GAP;
        end else if (!req_valid[owner_q]) begin
          state_d = GAP;
        end else begin
          state_d = LOAD;
        end
      end
      GAP: begin
        if (gcnt_q == G_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b1;
      remaining_q <= '0;
      tcnt_q      <= '0;
      gcnt_q      <= '0;
      cs_n_q      <= 2'b11;
      rsp_data_q  <= '0;
      rsp_valid_q <= 2'b00;
      done_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rx_hit ? owner_oh : 2'b00;
      done_q      <= last_word ? owner_oh : 2'b00;
      if (rx_hit) rsp_data_q <= spi_rx_data;

      if (do_grant) begin
        owner_q     <= grant_sel;
        remaining_q <= (len_sel == '0) ? REM_ONE : {1'b0, len_sel};
      end else if (state_q == NEXT && remaining_q != '0) begin
        remaining_q <= remaining_q - REM_ONE;
      end

      if (state_q == LOAD) begin
        tcnt_q <= '0;
      end else if (state_q == WAIT_RX && tcnt_q != T_LAST) begin
        tcnt_q <= tcnt_q + TW'(1);
      end

      if (state_q == GAP) gcnt_q <= gcnt_q + GW'(1);
      else                gcnt_q <= '0;

      // Chip select follows the registered state, so it releases one cycle after NEXT.
      case (state_q)
        GRANT, LOAD, WAIT_RX, NEXT: cs_n_q <= ~owner_oh;
        default:                    cs_n_q <= 2'b11;
      endcase
    end
  end

  assign req_wready   = tx_fire ? owner_oh : 2'b00;
  assign spi_tx_valid = tx_fire;
  assign spi_tx_data  = tx_fire ? wdata_sel : '0;
  assign rsp_data     = rsp_data_q;
  assign rsp_valid    = rsp_valid_q;
  assign err          = timeout_hit ? owner_oh : 2'b00;
  assign done         = done_q | err;
  assign spi_cs_n     = cs_n_q;
  assign busy         = (state_q != IDLE);
  assign owner        = owner_q;

endmodule
